// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator machine.
// Owns PC/IR/MAR/MBR/ACC and drives the registered-read memory and the combinational ALU.
module control_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] alu_result,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [11:0] pc,
  output logic [15:0] acc,
  output logic [15:0] ir,
  output logic        halted,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH_A = 4'd0,
    S_FETCH_W = 4'd1,
    S_FETCH_R = 4'd2,
    S_DECODE  = 4'd3,
    S_EXEC_W  = 4'd4,
    S_EXEC_R  = 4'd5,
    S_EXEC_WB = 4'd6,
    S_STORE_W = 4'd7,
    S_HALTED  = 4'd8
  } state_e;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_LOADI = 4'hD;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [11:0] mar_q, mar_d;
  logic [15:0] mbr_q, mbr_d;
  logic [15:0] acc_q, acc_d;

  logic [3:0]  op;
  logic [11:0] addr;

  assign op   = ir_q[15:12];
  assign addr = ir_q[11:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH_A;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mar_q   <= '0;
      mbr_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    acc_d   = acc_q;
    case (state_q)
      // MAR only moves when the fetch actually starts, so a stall changes nothing.
      S_FETCH_A: begin
        if (run) begin
          mar_d   = pc_q;
          state_d = S_FETCH_W;
        end
      end
      S_FETCH_W: state_d = S_FETCH_R;
      S_FETCH_R: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 12'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        mar_d   = addr;
        state_d = S_FETCH_A;
        case (op)
          OP_HALT:  state_d = S_HALTED;
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_EXEC_W;
          OP_STORE: state_d = S_STORE_W;
          OP_SHL, OP_SHR: acc_d = alu_result;
          OP_JUMP:  pc_d = addr;
          OP_JZ:    if (acc_q == 16'h0000) pc_d = addr;
          OP_JNZ:   if (acc_q != 16'h0000) pc_d = addr;
          OP_LOADI: acc_d = {4'b0000, addr};
          default:  state_d = S_FETCH_A;
        endcase
      end
      S_EXEC_W: state_d = S_EXEC_R;
      S_EXEC_R: begin
        mbr_d   = mem_rdata;
        state_d = S_EXEC_WB;
      end
      S_EXEC_WB: begin
        acc_d   = (op == OP_LOAD) ? mbr_q : alu_result;
        state_d = S_FETCH_A;
      end
      S_STORE_W: state_d = S_FETCH_A;
      S_HALTED:  state_d = S_HALTED;
      default:   state_d = S_FETCH_A;
    endcase
  end

  always_comb begin
    mem_we    = (state_q == S_STORE_W) && !reset;
    halted    = (state_q == S_HALTED);
    dbg_state = state_q;
    case (op)
      OP_ADD:  alu_opcode = 4'b0000;
      OP_SUB:  alu_opcode = 4'b0001;
      OP_AND:  alu_opcode = 4'b1000;
      OP_OR:   alu_opcode = 4'b1001;
      OP_XOR:  alu_opcode = 4'b1010;
      OP_SHL:  alu_opcode = 4'b0100;
      OP_SHR:  alu_opcode = 4'b0101;
      default: alu_opcode = 4'b0000;
    endcase
  end

  assign mem_addr  = {4'b0000, mar_q};
  assign mem_wdata = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = mbr_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign ir        = ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: hosts memory and ALU, compares against an instruction-level model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [15:0] mem_rdata, alu_result;
  logic [15:0] mem_addr, mem_wdata, alu_a, alu_b, acc, ir;
  logic        mem_we, halted;
  logic [3:0]  alu_opcode, dbg_state;
  logic [11:0] pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  control_unit #(.RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_rdata(mem_rdata), .alu_result(alu_result),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .pc(pc), .acc(acc), .ir(ir), .halted(halted), .dbg_state(dbg_state)
  );

  // ALU stand-in driven purely by the published opcode map.
  always_comb begin
    case (alu_opcode)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      4'b0100: alu_result = {alu_a[14:0], 1'b0};
      4'b0101: alu_result = {1'b0, alu_a[15:1]};
      default: alu_result = 16'h0000;
    endcase
  end

  // Main memory with registered read; bench loads words through the ld_* side port.
  logic [15:0] mem [0:4095];
  logic        clr = 1'b0, ld_en = 1'b0;
  logic [11:0] ld_addr = 12'h0;
  logic [15:0] ld_data = 16'h0;

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
    else if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:0]];
  end

  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (mem_we) begin
      tests++;
      assert (prev_we !== 1'b1) else begin
        fails++;
        $error("FAIL we_back_to_back: observed 1 expected 0");
      end
    end
    prev_we <= mem_we;
  end

  // Instruction-level reference model.
  logic [15:0] m_mem [0:4095];
  logic [11:0] m_pc;
  logic [15:0] m_acc;

  task automatic model_run(output int cycles);
    logic [15:0] instr, opnd;
    logic [3:0]  op;
    logic [11:0] a;
    bit done;
    m_pc = 12'h000; m_acc = 16'h0; cycles = 0; done = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      instr = m_mem[m_pc];
      m_pc  = m_pc + 12'd1;
      op = instr[15:12]; a = instr[11:0]; opnd = m_mem[a];
      case (op)
        4'h0: begin cycles += 4; done = 1; end
        4'h1: begin m_acc = opnd; cycles += 7; end
        4'h2: begin m_mem[a] = m_acc; cycles += 5; end
        4'h3: begin m_acc = m_acc + opnd; cycles += 7; end
        4'h4: begin m_acc = m_acc - opnd; cycles += 7; end
        4'h5: begin m_acc = m_acc & opnd; cycles += 7; end
        4'h6: begin m_acc = m_acc | opnd; cycles += 7; end
        4'h7: begin m_acc = m_acc ^ opnd; cycles += 7; end
        4'h8: begin m_acc = m_acc << 1; cycles += 4; end
        4'h9: begin m_acc = m_acc >> 1; cycles += 4; end
        4'hA: begin m_pc = a; cycles += 4; end
        4'hB: begin if (m_acc == 0) m_pc = a; cycles += 4; end
        4'hC: begin if (m_acc != 0) m_pc = a; cycles += 4; end
        4'hD: begin m_acc = {4'h0, a}; cycles += 4; end
        default: cycles += 4;
      endcase
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic prep();
    reset = 1'b1; run = 1'b0;
    clr = 1'b1; tick(1); clr = 1'b0;
    for (int i = 0; i < 4096; i++) m_mem[i] = 16'h0000;
  endtask

  task automatic put(input logic [11:0] a, input logic [15:0] d);
    m_mem[a] = d;
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    tick(1);
    ld_en = 1'b0;
  endtask

  task automatic start();
    reset = 1'b1; run = 1'b0;
    tick(1);
    reset = 1'b0; run = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < budget) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic jump_case(input string tag, input logic [15:0] loadi, input logic [15:0] jmp,
                           input logic [11:0] exp_pc);
    prep();
    put(12'h000, loadi);
    put(12'h001, jmp);
    start();
    tick(8);
    check(tag, pc, exp_pc);
  endtask

  task automatic alu_case(input string tag, input logic [15:0] i0, input logic [15:0] i1,
                          input logic [15:0] dat, input logic [15:0] exp_acc);
    int cyc, ecyc;
    prep();
    put(12'h000, i0); put(12'h001, i1); put(12'h002, 16'h0000); put(12'h010, dat);
    model_run(ecyc);
    start();
    run_to_halt(100, cyc);
    check({tag, "_acc"}, acc, exp_acc);
    check({tag, "_cycles"}, cyc, ecyc);
  endtask

  initial begin
    int cyc, ecyc;
    logic [15:0] w;
    logic [3:0]  op;
    reset = 1'b1; run = 1'b0;

    // Reset state
    tick(2);
    check("rst_pc", pc, 12'h000);
    check("rst_acc", acc, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_we", mem_we, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_alu_op", alu_opcode, 4'b0000);
    check("rst_state", dbg_state, 4'd0);

    // Reference program
    prep();
    put(12'h000, 16'hD005); put(12'h001, 16'h3010); put(12'h002, 16'h2011);
    put(12'h003, 16'h0000); put(12'h010, 16'h0007);
    start();
    run_to_halt(100, cyc);
    check("prog_cycles", cyc, 20);
    check("prog_m11", mem[12'h011], 16'h000C);
    check("prog_pc", pc, 12'h004);
    check("prog_acc", acc, 16'h000C);
    run = 1'b0; tick(3); run = 1'b1; tick(3);
    check("halt_sticky", halted, 1'b1);
    check("halt_pc", pc, 12'h004);

    // Conditional jumps
    jump_case("jz_taken", 16'hD000, 16'hB020, 12'h020);
    jump_case("jz_not", 16'hD001, 16'hB020, 12'h002);
    jump_case("jnz_not", 16'hD000, 16'hC020, 12'h002);
    jump_case("jnz_taken", 16'hD001, 16'hC020, 12'h020);

    // PC wrap through a NOP at 0xFFF
    prep();
    put(12'h000, 16'hAFFF); put(12'hFFF, 16'hE000);
    start();
    tick(8);
    check("wrap_pc", pc, 12'h000);
    tick(1);
    check("wrap_state", dbg_state, 4'd1);
    check("wrap_mem_addr", mem_addr, 16'h0000);

    // ALU edge cases
    alu_case("sub", 16'hD003, 16'h4010, 16'h0005, 16'hFFFE);
    alu_case("shl", 16'h1010, 16'h8000, 16'h8001, 16'h0002);
    alu_case("shr", 16'h1010, 16'h9000, 16'h8001, 16'h4000);

    // Reset landing on the STORE_W cycle
    prep();
    put(12'h000, 16'hD0AB); put(12'h001, 16'h2050); put(12'h050, 16'h1234);
    start();
    tick(8);
    check("sw_state", dbg_state, 4'd7);
    reset = 1'b1;
    #1;
    check("sw_we_in_reset", mem_we, 1'b0);
    tick(1);
    check("sw_word", mem[12'h050], 16'h1234);
    check("sw_state_after", dbg_state, 4'd0);
    check("sw_acc", acc, 16'h0000);
    check("sw_pc", pc, 12'h000);

    // Stall with run low, then start
    prep();
    put(12'h000, 16'hD00A); put(12'h001, 16'h0000);
    tick(1);
    reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall_we", mem_we, 1'b0);
      check("stall_pc", pc, 12'h000);
      check("stall_state", dbg_state, 4'd0);
    end
    run = 1'b1;
    tick(1);
    check("go_fetch_w", dbg_state, 4'd1);
    check("go_mem_addr", mem_addr, 16'h0000);
    tick(1);
    check("go_fetch_r", dbg_state, 4'd2);
    tick(1);
    check("go_ir", ir, 16'hD00A);
    check("go_pc", pc, 12'h001);

    // Random forward-only programs against the model
    for (int t = 0; t < 6; t++) begin
      prep();
      for (int j = 0; j < 16; j++) put(12'h100 + 12'(j), 16'($urandom));
      for (int i = 0; i < 16; i++) begin
        op = 4'($urandom_range(1, 14));
        case (op)
          4'hA, 4'hB, 4'hC: w = {op, 12'($urandom_range(i + 1, 16))};
          4'h8, 4'h9, 4'hD, 4'hE: w = {op, 12'($urandom)};
          default: w = {op, 12'h100 + 12'($urandom_range(0, 15))};
        endcase
        put(12'(i), w);
      end
      put(12'h010, 16'h0000);
      model_run(ecyc);
      start();
      run_to_halt(ecyc + 20, cyc);
      check("rnd_cycles", cyc, ecyc);
      check("rnd_pc", pc, m_pc);
      check("rnd_acc", acc, m_acc);
      for (int j = 0; j < 16; j++)
        check("rnd_data", mem[12'h100 + 12'(j)], m_mem[12'h100 + 12'(j)]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
